// File: rtl/life_ctrl_pkg.sv
// Shared definitions for the life-loss game-flow controller: state encodings and widths.
package life_ctrl_pkg;

  localparam int unsigned LIFE_STATE_W = 3;

  // Encoding 7 is the only unused code; the FSM recovers from it to S_INIT.
  typedef enum logic [LIFE_STATE_W-1:0] {
    S_INIT     = 3'd0,
    S_CLEAR    = 3'd1,
    S_PLAY     = 3'd2,
    S_HIT      = 3'd3,
    S_CHECK    = 3'd4,
    S_INVULN   = 3'd5,
    S_GAMEOVER = 3'd6
  } life_state_e;

endpackage

// File: rtl/life_loss_controller_if.sv
// Signal bundle between game logic / lives register and the life-loss controller.
interface life_loss_controller_if;
  import life_ctrl_pkg::*;

  logic                    LifeCtrl_collision_InLow;
  logic                    LifeCtrl_start_InLow;
  logic                    LifeCtrl_lives_empty_InLow;
  logic                    LifeCtrl_substract_life_OutLow;
  logic                    LifeCtrl_clear_OutLow;
  logic                    LifeCtrl_invuln_Out;
  logic                    LifeCtrl_game_over_Out;
  logic [LIFE_STATE_W-1:0] LifeCtrl_state_OutBUS;

  // Game logic and the lives register side.
  modport master (
    output LifeCtrl_collision_InLow,
    output LifeCtrl_start_InLow,
    output LifeCtrl_lives_empty_InLow,
    input  LifeCtrl_substract_life_OutLow,
    input  LifeCtrl_clear_OutLow,
    input  LifeCtrl_invuln_Out,
    input  LifeCtrl_game_over_Out,
    input  LifeCtrl_state_OutBUS
  );

  // The controller itself.
  modport slave (
    input  LifeCtrl_collision_InLow,
    input  LifeCtrl_start_InLow,
    input  LifeCtrl_lives_empty_InLow,
    output LifeCtrl_substract_life_OutLow,
    output LifeCtrl_clear_OutLow,
    output LifeCtrl_invuln_Out,
    output LifeCtrl_game_over_Out,
    output LifeCtrl_state_OutBUS
  );
endinterface

// File: rtl/life_invuln_timer.sv
// Load/decrement down-counter with zero flag; timing source for the invulnerability window.
module life_invuln_timer #(
  parameter int unsigned INVULN_CNT_WIDTH = 26
) (
  input  logic                        RegPERDIO_VIDAS_CLOCK_50,
  input  logic                        RegPERDIO_VIDAS_RESET_InHigh,
  input  logic                        load_i,
  input  logic                        dec_i,
  input  logic [INVULN_CNT_WIDTH-1:0] load_val_i,
  output logic                        zero_o
);

  logic [INVULN_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge RegPERDIO_VIDAS_CLOCK_50 or posedge RegPERDIO_VIDAS_RESET_InHigh) begin
    if (RegPERDIO_VIDAS_RESET_InHigh) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/life_loss_controller.sv
// Game-flow FSM feeding the lives register: hit/clear pulses, invulnerability and game over.
// Optional macro LIFE_LOSS_COLLISION_SYNC_EN adds 2-flop synchronizers on collision and start.
module life_loss_controller
  import life_ctrl_pkg::*;
#(
  parameter int unsigned INVULN_CYCLES    = 50000000,
  parameter int unsigned INVULN_CNT_WIDTH = 26
) (
  input  logic                   RegPERDIO_VIDAS_CLOCK_50,
  input  logic                   RegPERDIO_VIDAS_RESET_InHigh,
  life_loss_controller_if.slave  ctrl_if
);

  localparam logic [INVULN_CNT_WIDTH-1:0] INVULN_LOAD = INVULN_CNT_WIDTH'(INVULN_CYCLES - 1);

  logic        collision_n;
  logic        start_n;
  logic        lives_empty_n;
  logic        tmr_load;
  logic        tmr_dec;
  logic        tmr_zero;
  life_state_e state_q, state_d;

  assign lives_empty_n = ctrl_if.LifeCtrl_lives_empty_InLow;

`ifdef LIFE_LOSS_COLLISION_SYNC_EN
  logic [1:0] col_sync_q, col_sync_d;
  logic [1:0] st_sync_q, st_sync_d;

  always_comb begin
    col_sync_d = {col_sync_q[0], ctrl_if.LifeCtrl_collision_InLow};
    st_sync_d  = {st_sync_q[0], ctrl_if.LifeCtrl_start_InLow};
  end

  // Synchronizers idle high so reset never looks like a collision or start request.
  always_ff @(posedge RegPERDIO_VIDAS_CLOCK_50 or posedge RegPERDIO_VIDAS_RESET_InHigh) begin
    if (RegPERDIO_VIDAS_RESET_InHigh) begin
      col_sync_q <= 2'b11;
      st_sync_q  <= 2'b11;
    end else begin
      col_sync_q <= col_sync_d;
      st_sync_q  <= st_sync_d;
    end
  end

  assign collision_n = col_sync_q[1];
  assign start_n     = st_sync_q[1];
`else
  assign collision_n = ctrl_if.LifeCtrl_collision_InLow;
  assign start_n     = ctrl_if.LifeCtrl_start_InLow;
`endif

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    case (state_q)
      S_INIT:     if (!start_n) state_d = S_CLEAR;
      S_CLEAR:    state_d = S_PLAY;
      S_PLAY:     if (!collision_n) state_d = S_HIT;
      S_HIT:      state_d = S_CHECK;
      // Lives register has absorbed the subtract by now, so its flag is current.
      S_CHECK: begin
        if (!lives_empty_n) begin
          state_d = S_GAMEOVER;
        end else begin
          state_d  = S_INVULN;
          tmr_load = 1'b1;
        end
      end
      S_INVULN:   if (tmr_zero) state_d = S_PLAY;
      S_GAMEOVER: if (!start_n) state_d = S_CLEAR;
      default:    state_d = S_INIT;
    endcase
  end

  always_ff @(posedge RegPERDIO_VIDAS_CLOCK_50 or posedge RegPERDIO_VIDAS_RESET_InHigh) begin
    if (RegPERDIO_VIDAS_RESET_InHigh) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign tmr_dec = (state_q == S_INVULN);

  life_invuln_timer #(
    .INVULN_CNT_WIDTH(INVULN_CNT_WIDTH)
  ) u_invuln_timer (
    .RegPERDIO_VIDAS_CLOCK_50    (RegPERDIO_VIDAS_CLOCK_50),
    .RegPERDIO_VIDAS_RESET_InHigh(RegPERDIO_VIDAS_RESET_InHigh),
    .load_i                      (tmr_load),
    .dec_i                       (tmr_dec),
    .load_val_i                  (INVULN_LOAD),
    .zero_o                      (tmr_zero)
  );

  // Moore outputs: decoded from the state register only.
  always_comb begin
    ctrl_if.LifeCtrl_substract_life_OutLow = (state_q != S_HIT);
    ctrl_if.LifeCtrl_clear_OutLow          = (state_q != S_CLEAR);
    ctrl_if.LifeCtrl_invuln_Out            = (state_q == S_INVULN);
    ctrl_if.LifeCtrl_game_over_Out         = (state_q == S_GAMEOVER);
    ctrl_if.LifeCtrl_state_OutBUS          = state_q;
  end

endmodule

// File: tb/tb_life_loss_controller.sv
// Bench for life_loss_controller: scheduled-frame reference model, lives register model, random play.
module tb_life_loss_controller;

  localparam int unsigned N_INV = 4;
`ifdef LIFE_LOSS_COLLISION_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef enum {K_INIT, K_CLEAR, K_PLAY, K_HIT, K_CHECK, K_INVULN, K_OVER} kind_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   cmp_en = 1'b0;

  life_loss_controller_if intf();

  life_loss_controller #(
    .INVULN_CYCLES   (N_INV),
    .INVULN_CNT_WIDTH(26)
  ) dut (
    .RegPERDIO_VIDAS_CLOCK_50    (clk),
    .RegPERDIO_VIDAS_RESET_InHigh(rst),
    .ctrl_if                     (intf)
  );

  always #5 clk = ~clk;

  // Reference model: current expected frame plus a queue of pre-scheduled frames.
  kind_e cur;
  kind_e sched[$];
  bit    col_h0, col_h1, st_h0, st_h1;
  int    lives = 3;
  logic  rec_sub = 1'b1, rec_clr = 1'b1;

  function automatic int code_of(kind_e k);
    case (k)
      K_INIT:   return 0;
      K_CLEAR:  return 1;
      K_PLAY:   return 2;
      K_HIT:    return 3;
      K_CHECK:  return 4;
      K_INVULN: return 5;
      default:  return 6;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    cur = K_INIT;
    sched.delete();
    col_h0 = 1'b1; col_h1 = 1'b1;
    st_h0  = 1'b1; st_h1  = 1'b1;
  endtask

  task automatic model_step();
    bit eff_col, eff_st;
    if (SYNC_LAT == 2) begin
      eff_col = col_h1; eff_st = st_h1;
      col_h1 = col_h0; col_h0 = intf.LifeCtrl_collision_InLow;
      st_h1  = st_h0;  st_h0  = intf.LifeCtrl_start_InLow;
    end else begin
      eff_col = intf.LifeCtrl_collision_InLow;
      eff_st  = intf.LifeCtrl_start_InLow;
    end
    if (sched.size() > 0) begin
      cur = sched.pop_front();
    end else begin
      case (cur)
        K_INIT, K_OVER: if (!eff_st) cur = K_CLEAR;
        K_CLEAR:        cur = K_PLAY;
        K_PLAY:         if (!eff_col) cur = K_HIT;
        K_HIT:          cur = K_CHECK;
        K_CHECK: begin
          if (!intf.LifeCtrl_lives_empty_InLow) begin
            cur = K_OVER;
          end else begin
            cur = K_INVULN;
            for (int i = 1; i < int'(N_INV); i++) sched.push_back(K_INVULN);
            sched.push_back(K_PLAY);
          end
        end
        default:        cur = K_PLAY;
      endcase
    end
  endtask

  // Lives register reacting to the pulses the DUT presented during the cycle just ended.
  task automatic lives_update();
    if (!rec_clr) lives = 3;
    else if (!rec_sub && lives > 0) lives = lives - 1;
    intf.LifeCtrl_lives_empty_InLow = (lives == 0) ? 1'b0 : 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1 lives_update();
    @(negedge clk);
    rec_sub = intf.LifeCtrl_substract_life_OutLow;
    rec_clr = intf.LifeCtrl_clear_OutLow;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_sub",   int'(intf.LifeCtrl_substract_life_OutLow), 1);
    check("rst_inv",   int'(intf.LifeCtrl_invuln_Out), 0);
    check("rst_state", int'(intf.LifeCtrl_state_OutBUS), 0);
    model_reset();
    rec_sub = 1'b1;
    rec_clr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Compare process: every falling edge, all outputs against the model frame.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("sub",       int'(intf.LifeCtrl_substract_life_OutLow), (cur == K_HIT)    ? 0 : 1);
      check("clr",       int'(intf.LifeCtrl_clear_OutLow),          (cur == K_CLEAR)  ? 0 : 1);
      check("invuln",    int'(intf.LifeCtrl_invuln_Out),            (cur == K_INVULN) ? 1 : 0);
      check("game_over", int'(intf.LifeCtrl_game_over_Out),         (cur == K_OVER)   ? 1 : 0);
      check("state",     int'(intf.LifeCtrl_state_OutBUS),          code_of(cur));
    end
  end

  task automatic start_pulse();
    intf.LifeCtrl_start_InLow = 1'b0;
    tick();
    intf.LifeCtrl_start_InLow = 1'b1;
    repeat (SYNC_LAT) tick();
  endtask

  initial begin
    int pulses[$];
    intf.LifeCtrl_collision_InLow   = 1'b1;
    intf.LifeCtrl_start_InLow       = 1'b1;
    intf.LifeCtrl_lives_empty_InLow = 1'b1;
    model_reset();
    #3;
    check("reset_sub",   int'(intf.LifeCtrl_substract_life_OutLow), 1);
    check("reset_clr",   int'(intf.LifeCtrl_clear_OutLow), 1);
    check("reset_inv",   int'(intf.LifeCtrl_invuln_Out), 0);
    check("reset_go",    int'(intf.LifeCtrl_game_over_Out), 0);
    check("reset_state", int'(intf.LifeCtrl_state_OutBUS), 0);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Start: one clear pulse, then play.
    start_pulse();
    check("start_clr",   int'(intf.LifeCtrl_clear_OutLow), 0);
    check("start_state", int'(intf.LifeCtrl_state_OutBUS), 1);
    tick();
    check("play_clr",    int'(intf.LifeCtrl_clear_OutLow), 1);
    check("play_state",  int'(intf.LifeCtrl_state_OutBUS), 2);

    // Held collision from 3 lives: three hits 7 cycles apart, then game over.
    intf.LifeCtrl_collision_InLow = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!intf.LifeCtrl_substract_life_OutLow) pulses.push_back(i);
    end
    check("held_pulses", pulses.size(), 3);
    if (pulses.size() == 3) begin
      check("held_gap1", pulses[1] - pulses[0], 7);
      check("held_gap2", pulses[2] - pulses[1], 7);
    end
    check("held_go",    int'(intf.LifeCtrl_game_over_Out), 1);
    check("held_lives", lives, 0);

    // Game over with collision and start together: start wins.
    start_pulse();
    intf.LifeCtrl_collision_InLow = 1'b1;
    check("restart_clr", int'(intf.LifeCtrl_clear_OutLow), 0);
    tick();
    check("restart_state", int'(intf.LifeCtrl_state_OutBUS), 2);
    check("restart_lives", lives, 3);

    // Single-cycle collision: pulse, check, window of N_INV cycles, back to play.
    intf.LifeCtrl_collision_InLow = 1'b0;
    tick();
    intf.LifeCtrl_collision_InLow = 1'b1;
    repeat (SYNC_LAT) tick();
    check("hit_sub", int'(intf.LifeCtrl_substract_life_OutLow), 0);
    tick();
    check("chk_state", int'(intf.LifeCtrl_state_OutBUS), 4);
    for (int i = 0; i < int'(N_INV); i++) begin
      tick();
      check("win_inv", int'(intf.LifeCtrl_invuln_Out), 1);
    end
    tick();
    check("win_end_inv",   int'(intf.LifeCtrl_invuln_Out), 0);
    check("win_end_state", int'(intf.LifeCtrl_state_OutBUS), 2);

    // Reset during the hit pulse, then during the window.
    intf.LifeCtrl_collision_InLow = 1'b0;
    tick();
    intf.LifeCtrl_collision_InLow = 1'b1;
    repeat (SYNC_LAT) tick();
    async_reset();
    repeat (3) tick();
    check("idle_after_rst", int'(intf.LifeCtrl_state_OutBUS), 0);
    start_pulse();
    tick();
    intf.LifeCtrl_collision_InLow = 1'b0;
    tick();
    intf.LifeCtrl_collision_InLow = 1'b1;
    repeat (SYNC_LAT + 3) tick();
    check("pre_rst_inv", int'(intf.LifeCtrl_invuln_Out), 1);
    async_reset();

    // Randomized play with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0)
        intf.LifeCtrl_collision_InLow = ~intf.LifeCtrl_collision_InLow;
      intf.LifeCtrl_start_InLow = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 299) == 0) async_reset();
      tick();
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
